// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode codes, frame FSM state encoding and the
// default error byte returned for an unrecognised opcode.
package alu_pkg;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] NOR = 6'b100111;

    localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4
    } frame_state_t;

    function automatic logic opcode_legal(input logic [5:0] op);
        case (op)
            ADD, SUB, AND, OR, XOR, SRA, SRL, NOR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_frame_ctrl_if.sv
// Byte-stream, ALU and status bundle of alu_frame_ctrl. The master modport is
// the frame controller; the slave modport is the surrounding system.
interface alu_frame_ctrl_if #(
    parameter int unsigned BITS_DATA = 8,
    parameter int unsigned BITS_OP   = 6
);
    logic [BITS_DATA-1:0] i_rx_data;
    logic                 i_rx_valid;
    logic [BITS_DATA-1:0] o_alu_a;
    logic [BITS_DATA-1:0] o_alu_b;
    logic [BITS_OP-1:0]   o_alu_op;
    logic [BITS_DATA-1:0] i_alu_result;
    logic [BITS_DATA-1:0] o_tx_data;
    logic                 o_tx_valid;
    logic                 i_tx_ready;
    logic                 o_drop;
    logic                 o_timeout;
    logic                 o_err;

    modport master (
        input  i_rx_data, i_rx_valid, i_alu_result, i_tx_ready,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_valid,
               o_drop, o_timeout, o_err
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_alu_result, i_tx_ready,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_valid,
               o_drop, o_timeout, o_err
    );
endinterface

// File: rtl/alu_frame_timer.sv
// Idle counter between frame bytes; o_expire is high in the last allowed idle
// cycle. TIMEOUT_CYCLES=0 removes the counter and never expires.
module alu_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign o_expire = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count_r;

            // Idle cycle counter, restarted by any accepted byte or leaving the wait states
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    count_r <= {CW{1'b0}};
                end else if (i_clear || !i_enable || (count_r == LAST)) begin
                    count_r <= {CW{1'b0}};
                end else begin
                    count_r <= count_r + CW'(1'b1);
                end
            end

            assign o_expire = i_enable && !i_clear && (count_r == LAST);
        end
    endgenerate

endmodule

// File: rtl/alu_frame_ctrl.sv
// Collects an (A, B, opcode) byte frame for the ALU and returns its result byte.
// Define ALU_FRAME_OPCHECK_EN to reject unknown opcodes with ERR_BYTE and o_err.
module alu_frame_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned          BITS_DATA      = 8,
    parameter int unsigned          BITS_OP        = 6,
    parameter int unsigned          TIMEOUT_CYCLES = 1000000,
    parameter logic [BITS_DATA-1:0] ERR_BYTE       = BITS_DATA'(ERR_BYTE_DEFAULT)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    alu_frame_ctrl_if.master   bus
);

    frame_state_t         state_r;
    frame_state_t         state_s;
    logic [BITS_DATA-1:0] alu_a_r;
    logic [BITS_DATA-1:0] alu_b_r;
    logic [BITS_OP-1:0]   alu_op_r;
    logic [BITS_DATA-1:0] tx_data_r;
    logic                 tx_valid_r;
    logic                 drop_r;
    logic                 timeout_r;
    logic                 err_r;
    logic                 timer_en_s;
    logic                 expire_s;

    assign timer_en_s = (state_r == WAIT_B) || (state_r == WAIT_OP);

    alu_frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (bus.i_rx_valid),
        .i_enable (timer_en_s),
        .o_expire (expire_s)
    );

    // Next-state decode; a byte on the expiry cycle takes priority over the timeout
    always_comb begin
        state_s = state_r;
        case (state_r)
            WAIT_A: begin
                if (bus.i_rx_valid) state_s = WAIT_B;
                else                state_s = WAIT_A;
            end
            WAIT_B: begin
                if (bus.i_rx_valid) state_s = WAIT_OP;
                else if (expire_s)  state_s = WAIT_A;
                else                state_s = WAIT_B;
            end
            WAIT_OP: begin
                if (bus.i_rx_valid) state_s = EXEC;
                else if (expire_s)  state_s = WAIT_A;
                else                state_s = WAIT_OP;
            end
            EXEC:    state_s = SEND;
            SEND: begin
                if (tx_valid_r && bus.i_tx_ready) state_s = WAIT_A;
                else                              state_s = SEND;
            end
            default: state_s = WAIT_A;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_r <= WAIT_A;
        else          state_r <= state_s;
    end

    // Operand capture, result capture and status pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alu_a_r    <= {BITS_DATA{1'b0}};
            alu_b_r    <= {BITS_DATA{1'b0}};
            alu_op_r   <= {BITS_OP{1'b0}};
            tx_data_r  <= {BITS_DATA{1'b0}};
            tx_valid_r <= 1'b0;
            drop_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            if ((state_r == WAIT_A) && bus.i_rx_valid) alu_a_r <= bus.i_rx_data;
            if ((state_r == WAIT_B) && bus.i_rx_valid) alu_b_r <= bus.i_rx_data;
            if ((state_r == WAIT_OP) && bus.i_rx_valid) alu_op_r <= bus.i_rx_data[BITS_OP-1:0];
            // err_r is high exactly during EXEC for an illegal opcode
            if (state_r == EXEC) tx_data_r <= err_r ? ERR_BYTE : bus.i_alu_result;
            tx_valid_r <= (state_s == SEND);
            drop_r     <= bus.i_rx_valid && ((state_r == EXEC) || (state_r == SEND));
            timeout_r  <= expire_s;
        end
    end

`ifdef ALU_FRAME_OPCHECK_EN
    // Illegal-opcode flag, raised for the EXEC cycle that follows the opcode byte
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (state_r == WAIT_OP) && bus.i_rx_valid &&
                     !opcode_legal(6'(bus.i_rx_data[BITS_OP-1:0]));
        end
    end
`else
    assign err_r = 1'b0;
`endif

    assign bus.o_alu_a    = alu_a_r;
    assign bus.o_alu_b    = alu_b_r;
    assign bus.o_alu_op   = alu_op_r;
    assign bus.o_tx_data  = tx_data_r;
    assign bus.o_tx_valid = tx_valid_r;
    assign bus.o_drop     = drop_r;
    assign bus.o_timeout  = timeout_r;
    assign bus.o_err      = err_r;

endmodule

// File: doc/alu_frame_ctrl.md
Name: alu_frame_ctrl

Overview:
- Front end that drives the team's combinational ALU.
- Collects a three-byte command frame (operand A, operand B, opcode) from a byte stream, such as a UART receiver, and presents the registered operands and opcode to the ALU.
- Captures the ALU result and returns it as one byte on an outbound valid/ready stream, such as a UART transmitter.
- A partially received frame is discarded after an idle timeout.

Parameters:
- BITS_DATA, 8, width of stream bytes, operands and result.
- BITS_OP, 6, opcode width. The opcode is taken from byte bits [BITS_OP-1:0]; BITS_OP <= BITS_DATA.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between frame bytes. 0 disables the timeout.
- ERR_BYTE, 8'hEE, byte returned for an illegal opcode (only used with the optional feature).

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_rx_data  in  BITS_DATA  inbound byte.
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
- o_alu_a  out  BITS_DATA  operand A to the ALU.
- o_alu_b  out  BITS_DATA  operand B to the ALU.
- o_alu_op  out  BITS_OP  opcode to the ALU.
- i_alu_result  in  BITS_DATA  ALU combinational result.
- o_tx_data  out  BITS_DATA  result byte.
- o_tx_valid  out  1  result byte available.
- i_tx_ready  in  1  sink accepts the byte.
- o_drop  out  1  one-cycle pulse: an inbound byte was ignored.
- o_timeout  out  1  one-cycle pulse: a partial frame was discarded.
- o_err  out  1  one-cycle pulse: an illegal opcode was received (optional feature only; otherwise tied 0).

Behaviour:
- Reset: all outputs are 0 and the FSM is in WAIT_A. Reset asserted mid-frame or mid-send aborts immediately; o_tx_valid drops asynchronously.
- FSM states:
  - WAIT_A: on i_rx_valid, register o_alu_a and go to WAIT_B.
  - WAIT_B: on i_rx_valid, register o_alu_b and go to WAIT_OP.
  - WAIT_OP: on i_rx_valid, register o_alu_op from i_rx_data[BITS_OP-1:0] (upper bits ignored) and go to EXEC.
  - EXEC: exactly one cycle. The ALU inputs are now stable, so capture i_alu_result into o_tx_data and go to SEND.
  - SEND: hold o_tx_valid=1. When o_tx_valid && i_tx_ready are sampled high, go to WAIT_A, and o_tx_valid=0 from the next cycle.
- Latency: the opcode strobe in cycle N gives o_tx_valid=1 in cycle N+2.
- Stability rules:
  - o_tx_data is stable while o_tx_valid=1.
  - o_alu_a/b/op hold their last-frame values until overwritten by the next frame's bytes.
- Bytes arriving in EXEC or SEND are not stored and pulse o_drop in the following cycle. No buffering.
- Timeout counter:
  - Counts only in WAIT_B and WAIT_OP, and clears whenever a byte is accepted or the FSM is in any other state.
  - If it reaches TIMEOUT_CYCLES-1 with no strobe, the next state is WAIT_A and o_timeout pulses. The registered operands are not cleared.
- If i_rx_valid and the timeout expiry coincide, the byte wins: it is accepted and there is no timeout.
- Arithmetic: none inside the block. The result is whatever the ALU produces, truncated to BITS_DATA.

Optional Feature:
- Macro: ALU_FRAME_OPCHECK_EN.
- With the macro defined:
  - In WAIT_OP the opcode is checked against the eight legal codes: 100000, 100010, 100100, 100101, 100110, 000011, 000010, 100111.
  - An illegal code still updates o_alu_op, but EXEC loads ERR_BYTE into o_tx_data instead of i_alu_result, and o_err pulses in the EXEC cycle.
- Without the macro: no check. The ALU default result (0) is returned, and o_err is constant 0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams ADD, SUB, AND, OR, XOR, SRA, SRL, NOR (6-bit values above), shared with the ALU;
  - the FSM state encoding (WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND);
  - the default ERR_BYTE.
- One sub-module, alu_frame_timer: the parameterised idle counter. Inputs are clear and enable; output is the expire pulse. Width is $clog2(TIMEOUT_CYCLES+1). It is disabled entirely when TIMEOUT_CYCLES=0.

Test Plan:
- ADD: bytes 0x05, 0x03, 0x20 with i_tx_ready=1 -> o_tx_data=0x08, o_tx_valid high exactly 1 cycle, starting 2 cycles after the opcode strobe.
- SUB and SRA:
  - 0x03, 0x05, 0x22 -> 0xFE.
  - 0x80, 0x02, 0x03 -> 0xE0.
  - 0x80, 0x02, 0x02 -> 0x20.
- Backpressure: i_tx_ready=0 for 10 cycles during SEND, with 2 bytes sent -> o_tx_valid and o_tx_data stable, o_drop pulses twice, output accepted when ready rises, FSM back in WAIT_A.
- Timeout: TIMEOUT_CYCLES=16, send 0x11 then idle 16 cycles -> o_timeout pulse. Then 0x02, 0x03, 0x20 -> 0x05.
- Byte coinciding with expiry: the strobe in the expiry cycle is accepted with no o_timeout pulse.
- Reset mid-frame (after byte A) and mid-SEND -> all outputs 0, the next frame 0x01, 0x01, 0x25 returns 0x01.
- Illegal opcode 0x3F: returns 0x00 without ALU_FRAME_OPCHECK_EN. With it defined, returns 0xEE and o_err pulses once.
